// File: rtl/unidade_controle.sv
// Fetch/decode/execute sequencer in front of the 4-bit ALU (ula): reads 12-bit
// instructions from a synchronous ROM, keeps a 4x4 register file, writes back ALU results.
module unidade_controle #(
    parameter int unsigned PC_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] instr_addr,
    input  logic [11:0]     instr_data,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic [3:0]      alu_op,
    input  logic [7:0]      alu_result,
    input  logic            alu_sinal,
    output logic [7:0]      result_out,
    output logic            result_sign,
    output logic            result_valid,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OPC_LDI  = 4'b1000;
    localparam logic [3:0] OPC_HALT = 4'b1111;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    // IR keeps {opc, rd, rs}; the immediate is consumed directly at decode.
    logic [7:0]      ir_q, ir_d;
    logic [3:0][3:0] rf_q, rf_d;
    logic [7:0]      res_q, res_d;
    logic            sign_q, sign_d;

    logic [3:0] dec_opc;
    logic [1:0] dec_rd;
    logic [3:0] dec_imm;
    logic [3:0] ir_opc;
    logic [1:0] ir_rd;
    logic [1:0] ir_rs;

    assign dec_opc = instr_data[11:8];
    assign dec_rd  = instr_data[7:6];
    assign dec_imm = instr_data[3:0];
    assign ir_opc  = ir_q[7:4];
    assign ir_rd   = ir_q[3:2];
    assign ir_rs   = ir_q[1:0];

    function automatic logic is_alu_op(input logic [3:0] opc);
        return (opc != 4'b0000) && (opc <= 4'b0111);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            rf_q    <= '0;
            res_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rf_q    <= rf_d;
            res_q   <= res_d;
            sign_q  <= sign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rf_d    = rf_q;
        res_d   = res_q;
        sign_d  = sign_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d = instr_data[11:4];
                if (is_alu_op(dec_opc)) begin
                    state_d = S_EXEC;
                end else if (dec_opc == OPC_HALT) begin
                    state_d = S_HALT;
                end else begin
                    if (dec_opc == OPC_LDI) begin
                        rf_d[dec_rd] = dec_imm;
                        res_d        = {4'b0000, dec_imm};
                        sign_d       = 1'b0;
                    end
                    state_d = S_WB;
                end
            end
            S_EXEC: state_d = S_WAIT;
            S_WAIT: begin
                // ula registered its result on the EXEC exit edge
                rf_d[ir_rd] = alu_result[3:0];
                res_d       = alu_result;
                sign_d      = alu_sinal;
                state_d     = S_WB;
            end
            S_WB: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (state_q == S_EXEC || state_q == S_WAIT) begin
            alu_a  = rf_q[ir_rd];
            alu_b  = rf_q[ir_rs];
            alu_op = ir_opc;
        end
    end

    assign instr_addr   = pc_q;
    assign result_out   = res_q;
    assign result_sign  = sign_q;
    assign result_valid = (state_q == S_WB) && (is_alu_op(ir_opc) || ir_opc == OPC_LDI);
    assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC)
                       || (state_q == S_WAIT) || (state_q == S_WB);
    assign halted       = (state_q == S_HALT);

endmodule
